// File: rtl/pll_sup_pkg.sv
// Shared definitions for the PLL lock supervisor: state encodings and counter sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pll_sup_pkg;

    localparam logic [1:0] ST_RESET_PLL = 2'd0;
    localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
    localparam logic [1:0] ST_STABLE    = 2'd2;
    localparam logic [1:0] ST_RUN       = 2'd3;

    typedef enum logic [1:0] {
        RESET_PLL = ST_RESET_PLL,
        WAIT_LOCK = ST_WAIT_LOCK,
        STABLE    = ST_STABLE,
        RUN       = ST_RUN
    } state_e;

    // One counter serves every state, so size it for the longest interval plus a spare bit.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser for asynchronous status bits, with synchronous clear.
// Latency: 2 clk cycles from input change to q.
// Backpressure: none, free-running sampler.
module pll_lock_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Sample the async input twice; both stages clear together.
    always_ff @(posedge clk) begin
        if (clr) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, waits for lock with timeout/retry, qualifies stability, holds system reset.
// Latency: all outputs registered; locked reaches the FSM after a 2-cycle synchroniser.
// Backpressure: none; relock_req is a single-cycle request acted on immediately.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 1000000,
    parameter int STABLE_CYCLES = 1024,
    parameter int FAILW         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             locked,
    input  logic             relock_req,
    output logic             pll_rst,
    output logic             rst_out,
    output logic             lock_lost,
    output logic             timeout,
    output logic [FAILW-1:0] fail_cnt,
    output logic [1:0]       st
);

    localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

    logic          locked_s;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cnt_restart;
    logic          fail_inc;
    logic          lock_lost_d, timeout_d;
    logic [FAILW-1:0] fail_d;
    logic          rst_hit, wait_hit, stable_hit;

    pll_lock_sync #(.WIDTH(1)) u_lock_sync (
        .clk (clk),
        .clr (rst),
        .d   (locked),
        .q   (locked_s)
    );

    assign rst_hit    = (cnt_q == CW'(RST_CYCLES - 1));
    assign wait_hit   = (cnt_q == CW'(LOCK_TIMEOUT - 1));
    assign stable_hit = (cnt_q == CW'(STABLE_CYCLES - 1));
    assign st         = state_q;

    // Next-state, event pulses and counter update. Lock loss beats relock in RUN;
    // in WAIT_LOCK a lock seen on the timeout edge wins, and timeout beats relock.
    always_comb begin
        state_d     = state_q;
        cnt_restart = 1'b0;
        fail_inc    = 1'b0;
        lock_lost_d = 1'b0;
        timeout_d   = 1'b0;
        case (state_q)
            RESET_PLL: begin
                if (relock_req)   cnt_restart = 1'b1;
                else if (rst_hit) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (locked_s && !relock_req) begin
                    state_d = STABLE;
                end else if (!locked_s && wait_hit) begin
                    timeout_d = 1'b1;
                    fail_inc  = 1'b1;
                    state_d   = RESET_PLL;
                end else if (relock_req) begin
                    state_d = RESET_PLL;
                end
            end
            STABLE: begin
                if (relock_req)      state_d = RESET_PLL;
                else if (!locked_s)  state_d = WAIT_LOCK;
                else if (stable_hit) state_d = RUN;
            end
            RUN: begin
                if (!locked_s) begin
                    lock_lost_d = 1'b1;
                    fail_inc    = 1'b1;
                    state_d     = RESET_PLL;
                end else if (relock_req) begin
                    state_d = RESET_PLL;
                end
            end
            default: state_d = RESET_PLL;
        endcase

        if (state_d != state_q || cnt_restart) cnt_d = '0;
        else if (state_q == RUN)               cnt_d = cnt_q;
        else                                   cnt_d = cnt_q + 1'b1;

        if (fail_inc && fail_cnt != {FAILW{1'b1}}) fail_d = fail_cnt + 1'b1;
        else                                       fail_d = fail_cnt;
    end

    // Register state and all outputs; pll_rst/rst_out follow the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RESET_PLL;
            cnt_q     <= '0;
            pll_rst   <= 1'b1;
            rst_out   <= 1'b1;
            lock_lost <= 1'b0;
            timeout   <= 1'b0;
            fail_cnt  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pll_rst   <= (state_d == RESET_PLL);
            rst_out   <= (state_d != RUN);
            lock_lost <= lock_lost_d;
            timeout   <= timeout_d;
            fail_cnt  <= fail_d;
        end
    end

endmodule
